goldschmidt_seq: RTL
====================

GOLDSCHMIDT_SEQ -- requirements
Module: goldschmidt_seq

Interface
REQ-001 Parameter ITER, default 6, SHALL set the number of Goldschmidt iterations including the initial IA multiply; legal 2..16.
REQ-002 Parameter ROUND_CYC, default 2, SHALL set rounding/normalise wait cycles after the remainder cycle; legal 1..8.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request a new divide; sampled only in IDLE.
REQ-006 abort  input  1  cancel the operation in progress.
REQ-007 rm_in  input  2  rounding mode, captured on accepted start.
REQ-008 res_ack  input  1  consumer acknowledge of the result.
REQ-009 sel_mux3  output  2  multiplier operand-B select: 00=IA, 01=C register, 10=remainder path.
REQ-010 sel_mux4  output  2  multiplier operand-A select: 00=numerator, 01=denominator, 10=A register, 11=B register.
REQ-011 en_a, en_b, en_rem  output  1 each  load enables for the A, B and remainder registers.
REQ-012 rm_q  output  2  rounding mode held for the operation.
REQ-013 iter_cnt  output  clog2(ITER+1)  current iteration number; 0 in IDLE.
REQ-014 busy  output  1  high from INIT_A through the last ROUND cycle.
REQ-015 done  output  1  result valid; held until acknowledged.

Function
REQ-016 The FSM SHALL have the states IDLE, INIT_A, INIT_B, ITER_A, ITER_B, REM, ROUND and DONE.
REQ-017 IDLE SHALL drive sel_mux3=00, sel_mux4=00 and all enables 0; start=1 moves it to INIT_A and captures rm_in into rm_q.
REQ-018 INIT_A SHALL drive sel_mux4=00, sel_mux3=00, en_a=1, iter_cnt=1, then move to INIT_B.
REQ-019 INIT_B SHALL drive sel_mux4=01, sel_mux3=00, en_b=1, then move to ITER_A, incrementing iter_cnt.
REQ-020 ITER_A SHALL drive sel_mux4=10, sel_mux3=01, en_a=1, then move to ITER_B.
REQ-021 ITER_B SHALL drive sel_mux4=11, sel_mux3=01, en_b=1; if iter_cnt==ITER it SHALL move to REM, otherwise it SHALL move to ITER_A and increment iter_cnt.
REQ-022 REM SHALL drive sel_mux4=10, sel_mux3=10, en_rem=1, en_a=en_b=0 for exactly one cycle, then move to ROUND.
REQ-023 ROUND SHALL hold sel_mux4=10, sel_mux3=10 with all enables 0 for ROUND_CYC cycles, counted by an internal counter, then move to DONE.
REQ-024 DONE SHALL assert done=1 with busy=0 and all enables 0, and SHALL remain in DONE until res_ack=1, then move to IDLE.
REQ-025 Exactly one of en_a, en_b, en_rem SHALL be high in INIT_A, INIT_B, ITER_A, ITER_B and REM; none SHALL be high in any other state.
REQ-026 Latency with start accepted at edge E0: busy SHALL be high from cycle 1, REM SHALL occur at cycle 2*ITER+1, and done SHALL rise at cycle 2*ITER+ROUND_CYC+2 (16 for the defaults).
REQ-027 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-028 start=1 and res_ack=1 together in DONE SHALL return the FSM to IDLE only; a new start SHALL be required in a later cycle.
REQ-029 abort=1 in any state other than IDLE or DONE SHALL return the FSM to IDLE on the next edge with enables 0 and iter_cnt=0; abort SHALL have no effect in IDLE or DONE.
REQ-030 res_ack outside DONE SHALL be ignored.
REQ-031 rm_q SHALL hold its value until the next accepted start, including across abort.

Reset
REQ-032 With reset=0 at a rising edge, the block SHALL enter IDLE with sel_mux3=00, sel_mux4=00, en_a=en_b=en_rem=0, rm_q=00, iter_cnt=0, busy=0 and done=0.
REQ-033 Reset SHALL take priority over start, abort and res_ack, including mid-operation and in DONE.

Verification
REQ-034 Defaults, start pulse, rm_in=01 -> mux/enable trace 00/00/A, 01/00/B, then (10/01/A, 11/01/B)x5, 10/10/REM, 2 idle cycles; done at cycle 16; rm_q=01.
REQ-035 ITER=2, ROUND_CYC=1 -> exactly one ITER_A/ITER_B pair; REM at cycle 5; done at cycle 7.
REQ-036 Start held high continuously with res_ack pulsed in DONE -> back-to-back operations separated by one IDLE cycle; no start accepted while busy.
REQ-037 abort at cycle 7 (ITER_A) -> next cycle IDLE, enables 0, iter_cnt=0; a subsequent start runs a full sequence from INIT_A.
REQ-038 reset=0 at cycle 9, then in DONE -> all outputs at their reset values on the next edge; done stays low until a new start completes.
REQ-039 res_ack withheld for 20 cycles in DONE -> done stays 1, enables stay 0; res_ack together with start -> IDLE, no new operation.

Source files
------------

// File: rtl/goldschmidt_seq.sv
// Control sequencer for an iterative Goldschmidt divider datapath.
// It steps the multiplier operand selects and the A/B/remainder register
// load enables through initial approximation, refinement iterations, a
// remainder cycle and a rounding wait. It then holds the result until the
// consumer acknowledges it.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   start     request a new divide (sampled only in IDLE)
//   abort     cancel the operation in progress
//   rm_in     rounding mode, captured when start is accepted
//   res_ack   consumer acknowledge of the result
//   sel_mux3  operand-B select: 00=IA, 01=C reg, 10=remainder path
//   sel_mux4  operand-A select: 00=num, 01=den, 10=A reg, 11=B reg
//   en_a/en_b/en_rem  register load enables
//   rm_q      rounding mode held for the operation
//   iter_cnt  current iteration number (0 in IDLE)
//   busy      operation in flight (INIT_A .. last ROUND cycle)
//   done      result valid, held until res_ack
module goldschmidt_seq #(
  parameter int unsigned ITER      = 6,
  parameter int unsigned ROUND_CYC = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [1:0]                   rm_in,
  input  logic                         res_ack,
  output logic [1:0]                   sel_mux3,
  output logic [1:0]                   sel_mux4,
  output logic                         en_a,
  output logic                         en_b,
  output logic                         en_rem,
  output logic [1:0]                   rm_q,
  output logic [$clog2(ITER+1)-1:0]    iter_cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned IW = $clog2(ITER + 1);
  localparam int unsigned RW = $clog2(ROUND_CYC + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_A = 3'd1,
    INIT_B = 3'd2,
    ITER_A = 3'd3,
    ITER_B = 3'd4,
    REM    = 3'd5,
    ROUND  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] iter_n;
  logic [RW-1:0] round_cnt;
  logic [RW-1:0] round_n;

  // Next state and counter updates.
  always_comb begin
    state_n = state;
    iter_n  = iter_cnt;
    round_n = round_cnt;
    unique case (state)
      IDLE: begin
        iter_n = '0;
        if (start) begin
          state_n = INIT_A;
          iter_n  = IW'(1);
        end
      end
      INIT_A: state_n = INIT_B;
      INIT_B: begin
        state_n = ITER_A;
        iter_n  = iter_cnt + IW'(1);
      end
      ITER_A: state_n = ITER_B;
      ITER_B: begin
        if (iter_cnt == IW'(ITER)) begin
          state_n = REM;
        end else begin
          state_n = ITER_A;
          iter_n  = iter_cnt + IW'(1);
        end
      end
      REM: begin
        state_n = ROUND;
        round_n = '0;
      end
      ROUND: begin
        if (round_cnt == RW'(ROUND_CYC - 1)) begin
          state_n = DONE;
        end else begin
          round_n = round_cnt + RW'(1);
        end
      end
      DONE: begin
        // start in the same cycle as res_ack is deliberately not honoured
        if (res_ack) begin
          state_n = IDLE;
          iter_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // abort cancels only an operation that is actually in flight
    if (abort && (state != IDLE) && (state != DONE)) begin
      state_n = IDLE;
      iter_n  = '0;
    end
  end

  // State register; outputs are decoded from the next state so they are
  // registered and line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      iter_cnt  <= '0;
      round_cnt <= '0;
      rm_q      <= 2'b00;
      sel_mux3  <= 2'b00;
      sel_mux4  <= 2'b00;
      en_a      <= 1'b0;
      en_b      <= 1'b0;
      en_rem    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      iter_cnt  <= iter_n;
      round_cnt <= round_n;
      if ((state == IDLE) && start) begin
        rm_q <= rm_in;
      end
      sel_mux3 <= 2'b00;
      sel_mux4 <= 2'b00;
      en_a     <= 1'b0;
      en_b     <= 1'b0;
      en_rem   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      unique case (state_n)
        INIT_A: begin
          en_a <= 1'b1;
          busy <= 1'b1;
        end
        INIT_B: begin
          sel_mux4 <= 2'b01;
          en_b     <= 1'b1;
          busy     <= 1'b1;
        end
        ITER_A: begin
          sel_mux4 <= 2'b10;
          sel_mux3 <= 2'b01;
          en_a     <= 1'b1;
          busy     <= 1'b1;
        end
        ITER_B: begin
          sel_mux4 <= 2'b11;
          sel_mux3 <= 2'b01;
          en_b     <= 1'b1;
          busy     <= 1'b1;
        end
        REM: begin
          sel_mux4 <= 2'b10;
          sel_mux3 <= 2'b10;
          en_rem   <= 1'b1;
          busy     <= 1'b1;
        end
        ROUND: begin
          sel_mux4 <= 2'b10;
          sel_mux3 <= 2'b10;
          busy     <= 1'b1;
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
